// File: rtl/pattern_pkg.sv
// pattern_pkg: shared sequencer state type plus work-mode and deltaX codes.
package pattern_pkg;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FSYNC  = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_HBLANK = 3'd3,
    ST_LSYNC  = 3'd4,
    ST_VBLANK = 3'd5
  } seq_state_t;
  localparam logic [2:0] IDLE_MODE = 3'b000;
  localparam logic [2:0] REGULAR   = 3'b001;
  localparam logic [2:0] INVERT    = 3'b010;
  localparam logic [2:0] CHECKER   = 3'b011;
  localparam logic [2:0] H_BARS    = 3'b100;
  localparam logic [2:0] V_BARS    = 3'b101;
  localparam logic [2:0] GRAY_MODE = 3'b110;
  localparam logic [2:0] RAMP_MODE = 3'b111;
  localparam logic [1:0] DX_1 = 2'b00;
  localparam logic [1:0] DX_2 = 2'b01;
  localparam logic [1:0] DX_4 = 2'b10;
  localparam logic [1:0] DX_8 = 2'b11;
endpackage

// File: rtl/frame_sequencer_blank_timer.sv
// blank_timer: loadable down-counter; done while the count sits at zero.
module blank_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic [W-1:0] count,
  output logic         done
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (load) count <= value;
    else if (count != '0) count <= count - 1'b1;
  assign done = count == '0;
endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: frame/line strobe generator with blanking and frame-latched config.
// Optional FRAME_SEQ_FRAME_CNT_EN adds a wrapping 16-bit frame_cnt output.
module frame_sequencer
  import pattern_pkg::*;
#(
  parameter int PIX_PER_LINE    = 1290,
  parameter int LINES_PER_FRAME = 16,
  parameter int HBLANK          = 4,
  parameter int VBLANK          = 8,
  localparam int PW = $clog2(PIX_PER_LINE),
  localparam int LW = $clog2(LINES_PER_FRAME) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [2:0]    Mode_in,
  input  logic [1:0]    X_in,
  output logic          f_sync,
  output logic          sync,
  output logic          endLine,
  output logic          endFrame,
  output logic [2:0]    Mode,
  output logic [1:0]    X,
  output logic [PW-1:0] pix_cnt,
  output logic [LW-1:0] line_cnt,
`ifdef FRAME_SEQ_FRAME_CNT_EN
  output logic [15:0]   frame_cnt,
`endif
  output logic          busy
);
  localparam int TMAX = PIX_PER_LINE > HBLANK ? (PIX_PER_LINE > VBLANK ? PIX_PER_LINE : VBLANK)
                                              : (HBLANK > VBLANK ? HBLANK : VBLANK);
  localparam int TW = $clog2(TMAX);
  seq_state_t state, state_n;
  logic [LW-1:0] line_q, line_n;
  logic [TW-1:0] t_cnt, t_val;
  logic t_load, t_done;
  logic [2:0] mode_q;
  logic [1:0] x_q;
  blank_timer #(.W(TW)) u_timer (
    .clk(clk), .rst_n(rst_n), .load(t_load), .value(t_val), .count(t_cnt), .done(t_done)
  );
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   state_n = enable ? ST_FSYNC : ST_IDLE;
      ST_FSYNC:  state_n = ST_ACTIVE;
      ST_ACTIVE: state_n = t_done ? ST_HBLANK : ST_ACTIVE;
      ST_HBLANK: state_n = !t_done ? ST_HBLANK
                         : line_q < LW'(LINES_PER_FRAME - 1) ? ST_LSYNC : ST_VBLANK;
      ST_LSYNC:  state_n = ST_ACTIVE;
      ST_VBLANK: state_n = !t_done ? ST_VBLANK : enable ? ST_FSYNC : ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end
  // the timer is loaded with duration-1 on entry; the state leaves when it reaches zero
  assign t_load = state_n != state && state_n inside {ST_ACTIVE, ST_HBLANK, ST_VBLANK};
  assign t_val  = state_n == ST_ACTIVE ? TW'(PIX_PER_LINE - 1)
                : state_n == ST_HBLANK ? TW'(HBLANK - 1) : TW'(VBLANK - 1);
  assign line_n = state_n == ST_LSYNC ? line_q + 1'b1
                : state_n inside {ST_FSYNC, ST_IDLE} ? '0 : line_q;
  // outputs are registered from the current state, so they trail the state by one cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= ST_IDLE;
      line_q   <= '0;
      mode_q   <= '0;
      x_q      <= '0;
      f_sync   <= 1'b0;
      sync     <= 1'b0;
      endLine  <= 1'b0;
      endFrame <= 1'b0;
      busy     <= 1'b0;
      Mode     <= '0;
      X        <= '0;
      pix_cnt  <= '0;
      line_cnt <= '0;
    end else begin
      state    <= state_n;
      line_q   <= line_n;
      if (state_n == ST_FSYNC) begin
        mode_q <= Mode_in;
        x_q    <= X_in;
      end
      f_sync   <= state == ST_FSYNC;
      sync     <= state inside {ST_FSYNC, ST_LSYNC};
      endLine  <= state inside {ST_HBLANK, ST_VBLANK};
      endFrame <= line_q == LW'(LINES_PER_FRAME - 1)
                  && state inside {ST_LSYNC, ST_ACTIVE, ST_HBLANK, ST_VBLANK};
      busy     <= state != ST_IDLE;
      pix_cnt  <= state == ST_ACTIVE ? PW'(PIX_PER_LINE - 1) - PW'(t_cnt) : '0;
      line_cnt <= line_q;
      if (state == ST_FSYNC) begin
        Mode <= mode_q;
        X    <= x_q;
      end
    end
`ifdef FRAME_SEQ_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) frame_cnt <= '0;
    else if (state == ST_FSYNC) frame_cnt <= frame_cnt + 1'b1;
`endif
endmodule
